// File: rtl/n2_idu_instr_encoder.sv
// RV32IM (+ custom IRQ / counter) instruction encoder with an output FIFO.
// Turns an enumerated micro-op plus operand fields into a 32-bit instruction word.
module n2_idu_instr_encoder #(
    parameter int DEPTH             = 4,
    parameter bit ENABLE_COUNTERS   = 1'b1,
    parameter bit ENABLE_COUNTERS64 = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    flush_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [5:0]              req_op_i,
    input  logic [4:0]              req_rd_i,
    input  logic [4:0]              req_rs1_i,
    input  logic [4:0]              req_rs2_i,
    input  logic [31:0]             req_imm_i,
    output logic                    instr_valid_o,
    input  logic                    instr_ready_i,
    output logic [31:0]             instr_o,
    output logic                    instr_err_o,
    output logic                    illegal_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_CUSTOM = 7'b0001011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        FMT_U, FMT_J, FMT_I, FMT_SH, FMT_B, FMT_S, FMT_R,
        FMT_CUST, FMT_CSR, FMT_SYS, FMT_ILL
    } fmt_e;

    fmt_e        fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] f12;
    logic        legal;
    logic [31:0] enc_word;
    logic        enc_err;

    // Op enum -> instruction format and fixed opcode/funct fields.
    always_comb begin
        fmt = FMT_ILL;
        opc = 7'b0;
        f3  = 3'b0;
        f7  = 7'b0;
        f12 = 12'h000;
        case (req_op_i)
            6'd0:  begin fmt = FMT_U; opc = OPC_LUI; end
            6'd1:  begin fmt = FMT_U; opc = OPC_AUIPC; end
            6'd2:  begin fmt = FMT_J; opc = OPC_JAL; end
            6'd3:  begin fmt = FMT_I; opc = OPC_JALR; end
            6'd4:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b000; end
            6'd5:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b001; end
            6'd6:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b100; end
            6'd7:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b101; end
            6'd8:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b110; end
            6'd9:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b111; end
            6'd10: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b000; end
            6'd11: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b001; end
            6'd12: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b010; end
            6'd13: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b100; end
            6'd14: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b101; end
            6'd15: begin fmt = FMT_S; opc = OPC_STORE; f3 = 3'b000; end
            6'd16: begin fmt = FMT_S; opc = OPC_STORE; f3 = 3'b001; end
            6'd17: begin fmt = FMT_S; opc = OPC_STORE; f3 = 3'b010; end
            6'd18: begin fmt = FMT_I; opc = OPC_OPIMM; f3 = 3'b000; end
            6'd19: begin fmt = FMT_I; opc = OPC_OPIMM; f3 = 3'b010; end
            6'd20: begin fmt = FMT_I; opc = OPC_OPIMM; f3 = 3'b011; end
            6'd21: begin fmt = FMT_I; opc = OPC_OPIMM; f3 = 3'b100; end
            6'd22: begin fmt = FMT_I; opc = OPC_OPIMM; f3 = 3'b110; end
            6'd23: begin fmt = FMT_I; opc = OPC_OPIMM; f3 = 3'b111; end
            6'd24: begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = 3'b001; end
            6'd25: begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = 3'b101; end
            6'd26: begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = 3'b101; f7 = 7'b0100000; end
            6'd27: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b000; end
            6'd28: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b000; f7 = 7'b0100000; end
            6'd29: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b001; end
            6'd30: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b010; end
            6'd31: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b011; end
            6'd32: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b100; end
            6'd33: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b101; end
            6'd34: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b101; f7 = 7'b0100000; end
            6'd35: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b110; end
            6'd36: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b111; end
            6'd37: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b000; f7 = 7'b0000001; end
            6'd38: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b001; f7 = 7'b0000001; end
            6'd39: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b010; f7 = 7'b0000001; end
            6'd40: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b011; f7 = 7'b0000001; end
            6'd41: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b100; f7 = 7'b0000001; end
            6'd42: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b101; f7 = 7'b0000001; end
            6'd43: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b110; f7 = 7'b0000001; end
            6'd44: begin fmt = FMT_R; opc = OPC_OP; f3 = 3'b111; f7 = 7'b0000001; end
            6'd45: begin fmt = FMT_CUST; opc = OPC_CUSTOM; f7 = 7'b0000010; end
            6'd46: begin fmt = FMT_CUST; opc = OPC_CUSTOM; f7 = 7'b0000011; end
            6'd47: begin fmt = ENABLE_COUNTERS   ? FMT_CSR : FMT_ILL; opc = OPC_SYSTEM; f3 = 3'b010; f12 = 12'hC00; end
            6'd48: begin fmt = ENABLE_COUNTERS64 ? FMT_CSR : FMT_ILL; opc = OPC_SYSTEM; f3 = 3'b010; f12 = 12'hC80; end
            6'd49: begin fmt = ENABLE_COUNTERS   ? FMT_CSR : FMT_ILL; opc = OPC_SYSTEM; f3 = 3'b010; f12 = 12'hC02; end
            6'd50: begin fmt = ENABLE_COUNTERS64 ? FMT_CSR : FMT_ILL; opc = OPC_SYSTEM; f3 = 3'b010; f12 = 12'hC82; end
            6'd51: begin fmt = FMT_SYS; opc = OPC_SYSTEM; f12 = 12'h000; end
            6'd52: begin fmt = FMT_SYS; opc = OPC_SYSTEM; f12 = 12'h001; end
            default: fmt = FMT_ILL;
        endcase
    end

    // Sign-extension checks: the bits above the field's sign bit must all match it.
    logic fits_12, fits_13, fits_21;
    assign fits_12 = (&req_imm_i[31:11]) | ~(|req_imm_i[31:11]);
    assign fits_13 = ((&req_imm_i[31:12]) | ~(|req_imm_i[31:12])) & ~req_imm_i[0];
    assign fits_21 = ((&req_imm_i[31:20]) | ~(|req_imm_i[31:20])) & ~req_imm_i[0];

    always_comb begin
        enc_word = 32'h0;
        enc_err  = 1'b0;
        case (fmt)
            FMT_U: begin
                enc_word = {req_imm_i[31:12], req_rd_i, opc};
                enc_err  = |req_imm_i[11:0];
            end
            FMT_J: begin
                enc_word = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12], req_rd_i, opc};
                enc_err  = ~fits_21;
            end
            FMT_I: begin
                enc_word = {req_imm_i[11:0], req_rs1_i, f3, req_rd_i, opc};
                enc_err  = ~fits_12;
            end
            FMT_SH: begin
                enc_word = {f7, req_imm_i[4:0], req_rs1_i, f3, req_rd_i, opc};
                enc_err  = |req_imm_i[31:5];
            end
            FMT_B: begin
                enc_word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, f3,
                            req_imm_i[4:1], req_imm_i[11], opc};
                enc_err  = ~fits_13;
            end
            FMT_S: begin
                enc_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, f3, req_imm_i[4:0], opc};
                enc_err  = ~fits_12;
            end
            FMT_R:    enc_word = {f7, req_rs2_i, req_rs1_i, f3, req_rd_i, opc};
            FMT_CUST: enc_word = {f7, 5'b0, req_rs1_i, 3'b000, req_rd_i, opc};
            FMT_CSR:  enc_word = {f12, 5'b0, f3, req_rd_i, opc};
            FMT_SYS:  enc_word = {f12, 5'b0, 3'b000, 5'b0, opc};
            default:  enc_word = 32'h0;
        endcase
    end

    assign legal = (fmt != FMT_ILL);

    // Handshake: a request transfers on a rising edge where req_valid_i && req_ready_o;
    // the head transfers where instr_valid_o && instr_ready_i. flush_i blocks both.
    logic [32:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          illegal_q;
    logic          accept, push, pop;

    assign req_ready_o   = (count_q < DEPTH_C) && !flush_i;
    assign accept        = req_valid_i && req_ready_o;
    assign push          = accept && legal;
    assign instr_valid_o = (count_q != '0);
    assign pop           = instr_valid_o && instr_ready_i && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && !legal;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage needs no reset: an empty FIFO masks its contents at the output.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {enc_err, enc_word};
    end

    assign {instr_err_o, instr_o} = instr_valid_o ? mem_q[rd_ptr_q] : 33'h0;
    assign illegal_o = illegal_q;
    assign count_o   = count_q;

endmodule

// File: tb/tb_n2_idu_instr_encoder.sv
// Bench for n2_idu_instr_encoder: directed vector table, multi-cycle corner sequences
// and randomized requests checked against a field-arithmetic reference encoder.
module tb_n2_idu_instr_encoder;
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [5:0]  req_op_i;
    logic [4:0]  req_rd_i, req_rs1_i, req_rs2_i;
    logic [31:0] req_imm_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic        instr_err_o;
    logic        illegal_o;
    logic [2:0]  count_o;

    // second instance with 64-bit counter reads disabled
    logic        r2_valid, r2_ready, r2_rdy, r2_ivalid, r2_err, r2_ill;
    logic [5:0]  r2_op;
    logic [31:0] r2_instr;
    logic [2:0]  r2_count;
    logic [4:0]  zero5 = 5'd0;
    logic [31:0] zero32 = 32'd0;

    n2_idu_instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_rd_i(req_rd_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_imm_i(req_imm_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
        .instr_err_o(instr_err_o), .illegal_o(illegal_o), .count_o(count_o)
    );

    n2_idu_instr_encoder #(.DEPTH(DEPTH), .ENABLE_COUNTERS64(1'b0)) dut_nc64 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(1'b0),
        .req_valid_i(r2_valid), .req_ready_o(r2_ready), .req_op_i(r2_op),
        .req_rd_i(zero5), .req_rs1_i(zero5), .req_rs2_i(zero5), .req_imm_i(zero32),
        .instr_valid_o(r2_ivalid), .instr_ready_i(r2_rdy), .instr_o(r2_instr),
        .instr_err_o(r2_err), .illegal_o(r2_ill), .count_o(r2_count)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference encoder: builds the word from field positions with plain arithmetic
    function automatic void ref_encode(input logic [5:0] op, input logic [4:0] rd, rs1, rs2,
                                       input logic [31:0] imm, input bit en_c, en_c64,
                                       output bit legal, output logic [32:0] word);
        logic [31:0] w, rdv, r1, r2, f3, f7;
        logic [31:0] br_f3 [6];
        logic [31:0] ld_f3 [5];
        logic [31:0] oi_f3 [6];
        logic [31:0] r_f3 [10];
        logic [31:0] r_f7 [10];
        logic [31:0] csr [4];
        int s, o;
        bit err;
        br_f3 = '{0, 1, 4, 5, 6, 7};
        ld_f3 = '{0, 1, 2, 4, 5};
        oi_f3 = '{0, 2, 3, 4, 6, 7};
        r_f3  = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        r_f7  = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
        csr   = '{32'hC00, 32'hC80, 32'hC02, 32'hC82};
        rdv = 32'(rd); r1 = 32'(rs1); r2 = 32'(rs2);
        s = $signed(imm); o = int'(op);
        legal = 1'b1; err = 1'b0; w = 32'h0;
        if (o <= 1) begin
            err = (imm % 4096) != 0;
            w = imm - (imm % 4096) + rdv * 128 + ((o == 0) ? 32'h37 : 32'h17);
        end else if (o == 2) begin
            err = (s < -1048576) || (s > 1048575) || imm[0];
            w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20)
              | (((imm >> 12) & 255) << 12) | (rdv << 7) | 32'h6F;
        end else if (o == 3 || (o >= 10 && o <= 14) || (o >= 18 && o <= 23)) begin
            err = (s < -2048) || (s > 2047);
            if (o == 3)       begin f3 = 0;             f7 = 32'h67; end
            else if (o <= 14) begin f3 = ld_f3[o - 10]; f7 = 32'h03; end
            else              begin f3 = oi_f3[o - 18]; f7 = 32'h13; end
            w = ((imm & 4095) << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | f7;
        end else if (o >= 4 && o <= 9) begin
            err = (s < -4096) || (s > 4095) || imm[0];
            w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (r2 << 20) | (r1 << 15)
              | (br_f3[o - 4] << 12) | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
        end else if (o >= 15 && o <= 17) begin
            err = (s < -2048) || (s > 2047);
            w = (((imm >> 5) & 127) << 25) | (r2 << 20) | (r1 << 15) | (32'(o - 15) << 12)
              | ((imm & 31) << 7) | 32'h23;
        end else if (o >= 24 && o <= 26) begin
            err = imm > 31;
            f3 = (o == 24) ? 1 : 5;
            f7 = (o == 26) ? 32 : 0;
            w = (f7 << 25) | ((imm & 31) << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | 32'h13;
        end else if (o >= 27 && o <= 36) begin
            w = (r_f7[o - 27] << 25) | (r2 << 20) | (r1 << 15) | (r_f3[o - 27] << 12) | (rdv << 7) | 32'h33;
        end else if (o >= 37 && o <= 44) begin
            w = (32'd1 << 25) | (r2 << 20) | (r1 << 15) | (32'(o - 37) << 12) | (rdv << 7) | 32'h33;
        end else if (o == 45 || o == 46) begin
            w = (((o == 45) ? 32'd2 : 32'd3) << 25) | (r1 << 15) | (rdv << 7) | 32'h0B;
        end else if (o >= 47 && o <= 50) begin
            legal = (o == 47 || o == 49) ? en_c : en_c64;
            w = (csr[o - 47] << 20) | (32'd2 << 12) | (rdv << 7) | 32'h73;
        end else if (o == 51) begin
            w = 32'h00000073;
        end else if (o == 52) begin
            w = 32'h00100073;
        end else begin
            legal = 1'b0;
        end
        word = legal ? {err, w} : 33'h0;
    endfunction

    // scoreboard: cycle model of the queue, sampled on the falling edge
    logic [32:0] exp_q[$];
    bit          drv_legal;
    logic [32:0] drv_word;
    bit          acc_seen;
    bit          exp_ill;

    always @(negedge clk_i) begin
        bit exp_rdy, exp_vld, acc, pop;
        if (!rst_n_i) begin
            exp_q.delete();
            exp_ill  = 1'b0;
            acc_seen = 1'b0;
            chk("rst_valid", instr_valid_o, 0);
            chk("rst_count", count_o, 0);
            chk("rst_instr", {instr_err_o, instr_o}, 0);
            chk("rst_illegal", illegal_o, 0);
        end else begin
            exp_vld = exp_q.size() != 0;
            exp_rdy = (exp_q.size() < DEPTH) && !flush_i;
            chk("count", count_o, exp_q.size());
            chk("valid", instr_valid_o, exp_vld);
            chk("req_ready", req_ready_o, exp_rdy);
            chk("illegal", illegal_o, exp_ill);
            if (exp_vld) chk("head", {instr_err_o, instr_o}, exp_q[0]);
            acc = req_valid_i && exp_rdy;
            pop = exp_vld && instr_ready_i && !flush_i;
            acc_seen = acc;
            exp_ill  = acc && !drv_legal;
            if (flush_i) exp_q.delete();
            else begin
                if (pop) void'(exp_q.pop_front());
                if (acc && drv_legal) exp_q.push_back(drv_word);
            end
        end
    end

    // driver tasks (start and end 1 time unit after a rising edge)
    task automatic send(input logic [5:0] op, input logic [4:0] rd, rs1, rs2,
                        input logic [31:0] imm, input bit legal, input logic [32:0] word);
        bit done = 1'b0;
        req_op_i = op; req_rd_i = rd; req_rs1_i = rs1; req_rs2_i = rs2; req_imm_i = imm;
        drv_legal = legal; drv_word = word; req_valid_i = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk_i);
            done = acc_seen;
        end
        #1 req_valid_i = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: op %0d not accepted, expected accept within 200 cycles", op);
        end
    endtask

    task automatic send_model(input logic [5:0] op, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm);
        bit lg;
        logic [32:0] wd;
        ref_encode(op, rd, rs1, rs2, imm, 1'b1, 1'b1, lg, wd);
        send(op, rd, rs1, rs2, imm, lg, wd);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk_i);
        #1 chk("drain_empty", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        bit          legal;
        logic [32:0] word;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    bit rdy_rand = 1'b0;
    initial forever begin
        @(posedge clk_i);
        #1 if (rdy_rand) instr_ready_i = 1'($urandom_range(0, 1));
    end

    initial begin
        logic [31:0] bnd [10];
        logic [31:0] imm;
        bnd = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094,
                32'hFFFFF000, 32'd4096, 32'h000FFFFE, 32'h00100000, 32'hFFF00000};

        vecs[0]  = '{6'd18, 5'd1, 5'd0, 5'd0, 32'd5,          1'b1, {1'b0, 32'h00500093}};
        vecs[1]  = '{6'd0,  5'd5, 5'd0, 5'd0, 32'h12345000,   1'b1, {1'b0, 32'h123452B7}};
        vecs[2]  = '{6'd4,  5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   1'b1, {1'b0, 32'hFE208EE3}};
        vecs[3]  = '{6'd2,  5'd1, 5'd0, 5'd0, 32'd8,          1'b1, {1'b0, 32'h008000EF}};
        vecs[4]  = '{6'd37, 5'd3, 5'd1, 5'd2, 32'd0,          1'b1, {1'b0, 32'h022081B3}};
        vecs[5]  = '{6'd18, 5'd1, 5'd0, 5'd0, 32'd2048,       1'b1, {1'b1, 32'h80000093}};
        vecs[6]  = '{6'd4,  5'd0, 5'd0, 5'd0, 32'd3,          1'b1, {1'b1, 32'h00000163}};
        vecs[7]  = '{6'd24, 5'd1, 5'd1, 5'd0, 32'd32,         1'b1, {1'b1, 32'h00009093}};
        vecs[8]  = '{6'd47, 5'd10, 5'd0, 5'd0, 32'd0,         1'b1, {1'b0, 32'hC0002573}};
        vecs[9]  = '{6'd60, 5'd1, 5'd1, 5'd1, 32'd0,          1'b0, 33'h0};
        vecs[10] = '{6'd51, 5'd7, 5'd3, 5'd4, 32'd0,          1'b1, {1'b0, 32'h00000073}};
        vecs[11] = '{6'd52, 5'd0, 5'd0, 5'd0, 32'd0,          1'b1, {1'b0, 32'h00100073}};
        vecs[12] = '{6'd28, 5'd1, 5'd2, 5'd3, 32'd0,          1'b1, {1'b0, 32'h403100B3}};
        vecs[13] = '{6'd17, 5'd0, 5'd2, 5'd3, 32'hFFFFFFF8,   1'b1, {1'b0, 32'hFE312C23}};
        vecs[14] = '{6'd26, 5'd1, 5'd1, 5'd0, 32'd3,          1'b1, {1'b0, 32'h4030D093}};
        vecs[15] = '{6'd45, 5'd1, 5'd2, 5'd0, 32'd0,          1'b1, {1'b0, 32'h0401008B}};
        vecs[16] = '{6'd2,  5'd0, 5'd0, 5'd0, 32'h00100000,   1'b1, {1'b1, 32'h8000006F}};
        vecs[17] = '{6'd0,  5'd0, 5'd0, 5'd0, 32'h00000FFF,   1'b1, {1'b1, 32'h00000037}};
        vecs[18] = '{6'd50, 5'd2, 5'd0, 5'd0, 32'd0,          1'b1, {1'b0, 32'hC8202173}};

        rst_n_i = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; instr_ready_i = 1'b0;
        req_op_i = '0; req_rd_i = '0; req_rs1_i = '0; req_rs2_i = '0; req_imm_i = '0;
        drv_legal = 1'b1; drv_word = '0;
        r2_valid = 1'b0; r2_op = '0; r2_rdy = 1'b0;
        repeat (2) @(posedge clk_i);
        #3 rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // directed vectors, consumer always ready
        instr_ready_i = 1'b1;
        for (int i = 0; i < NV; i++)
            send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].legal, vecs[i].word);
        drain();

        // 64-bit counter reads disabled: op48 illegal, op49 still legal
        @(posedge clk_i); #1;
        r2_op = 6'd48; r2_valid = 1'b1;
        @(negedge clk_i) chk("nc64_ready", r2_ready, 1);
        @(posedge clk_i); #1 r2_valid = 1'b0;
        @(negedge clk_i);
        chk("nc64_illegal", r2_ill, 1);
        chk("nc64_count0", r2_count, 0);
        r2_op = 6'd49; r2_valid = 1'b1;
        @(posedge clk_i); #1 r2_valid = 1'b0;
        @(negedge clk_i);
        chk("nc64_ill_once", r2_ill, 0);
        chk("nc64_count1", r2_count, 1);
        chk("nc64_rdinstr", {r2_err, r2_instr}, {1'b0, 32'hC0202073});

        // fill to DEPTH with consumer stalled, then release it while a 5th request waits
        @(posedge clk_i); #1;
        instr_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send_model(6'd18, 5'(i + 1), 5'd0, 5'd0, 32'(i * 3));
        @(negedge clk_i);
        chk("full_count", count_o, 4);
        chk("full_ready", req_ready_o, 0);
        @(posedge clk_i); #1;
        fork
            send_model(6'd27, 5'd9, 5'd8, 5'd7, 32'd0);
            begin
                repeat (3) @(posedge clk_i);
                #1 instr_ready_i = 1'b1;
            end
        join
        drain();

        // flush with simultaneous push and pop against three entries
        instr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send_model(6'd21, 5'(i), 5'(i + 4), 5'd0, 32'(i));
        flush_i = 1'b1; instr_ready_i = 1'b1;
        req_op_i = 6'd18; req_imm_i = 32'd1; drv_legal = 1'b1; drv_word = {1'b0, 32'h00100013};
        req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0; req_valid_i = 1'b0;
        @(negedge clk_i) chk("flush_count", count_o, 0);

        // asynchronous reset mid-stream
        @(posedge clk_i); #1;
        instr_ready_i = 1'b0;
        send_model(6'd3, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF0);
        send_model(6'd30, 5'd1, 5'd2, 5'd3, 32'd0);
        #2 rst_n_i = 1'b0;
        #1;
        chk("async_valid", instr_valid_o, 0);
        chk("async_count", count_o, 0);
        @(negedge clk_i);
        #2 rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        instr_ready_i = 1'b1;
        send_model(6'd18, 5'd1, 5'd0, 5'd0, 32'd5);
        drain();

        // randomized traffic with a randomly stalling consumer
        rdy_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       imm = 32'($urandom_range(0, 40));
                1:       imm = $urandom;
                2:       imm = bnd[$urandom_range(0, 9)];
                default: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            endcase
            send_model(6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk_i); #1;
            end
        end
        rdy_rand = 1'b0;
        instr_ready_i = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
